// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - opcodes, FSM states and decode record for the multi-cycle sequencer
package alu_seq_ctrl_pkg;

  localparam logic [5:0] OP_HALT = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_NOR  = 6'd6;
  localparam logic [5:0] OP_SLT  = 6'd7;
  localparam logic [5:0] OP_SLL  = 6'd8;
  localparam logic [5:0] OP_SRL  = 6'd9;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd11;
  localparam logic [5:0] OP_ORI  = 6'd12;
  localparam logic [5:0] OP_SLTI = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd14;
  localparam logic [5:0] OP_SW   = 6'd15;
  localparam logic [5:0] OP_BEQ  = 6'd16;
  localparam logic [5:0] OP_BNE  = 6'd17;
  localparam logic [5:0] OP_BLT  = 6'd18;
  localparam logic [5:0] OP_BGE  = 6'd19;
  localparam logic [5:0] OP_BLTZ = 6'd20;
  localparam logic [5:0] OP_BGTZ = 6'd21;
  localparam logic [5:0] OP_LUI  = 6'd22;
  localparam logic [5:0] OP_J    = 6'd23;
  localparam logic [5:0] OP_JR   = 6'd24;
  localparam logic [5:0] OP_JAL  = 6'd25;

  localparam logic [4:0] REG_LINK = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    DEST_RD,
    DEST_RT,
    DEST_LINK
  } dest_sel_e;

  typedef struct packed {
    logic      writes_rf;
    dest_sel_e dest_sel;
    logic      is_mem;
    logic      is_store;
    logic      is_branch;
    logic      is_jump;
    logic      is_jr;
    logic      illegal;
  } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode classifier feeding the sequencer FSM
module alu_seq_decode
  import alu_seq_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o          = '0;
    dec_o.dest_sel = DEST_RD;
    case (op_i) inside
      [OP_ADD:OP_SRL]: begin
        dec_o.writes_rf = 1'b1;
        dec_o.dest_sel  = DEST_RD;
      end
      [OP_ADDI:OP_SLTI], OP_LUI: begin
        dec_o.writes_rf = 1'b1;
        dec_o.dest_sel  = DEST_RT;
      end
      OP_LW: begin
        dec_o.is_mem    = 1'b1;
        dec_o.writes_rf = 1'b1;
        dec_o.dest_sel  = DEST_RT;
      end
      OP_SW: begin
        dec_o.is_mem   = 1'b1;
        dec_o.is_store = 1'b1;
      end
      [OP_BEQ:OP_BGTZ]: dec_o.is_branch = 1'b1;
      OP_J:             dec_o.is_jump   = 1'b1;
      OP_JR:            dec_o.is_jr     = 1'b1;
      OP_JAL: begin
        dec_o.is_jump   = 1'b1;
        dec_o.writes_rf = 1'b1;
        dec_o.dest_sel  = DEST_LINK;
      end
      OP_HALT:          dec_o.illegal   = 1'b0;
      default:          dec_o.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer around the ALU
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_STEP     = 32'd1,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [31:0] RESET_PC    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_valid,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] alu_ins,
  output logic [31:0] alu_pc,
  input  logic [31:0] alu_c,
  input  logic        alu_jump,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   c_q, c_d;
  logic          jump_q, jump_d;
  logic [31:0]   ld_q, ld_d;
  logic          fault_q, fault_d;
  logic [31:0]   retired_q, retired_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [5:0]  op;
  dec_t        dec;
  logic [31:0] pc_seq;
  logic [31:0] pc_tgt;
  logic        commit;

  assign op     = ir_q[31:26];
  assign pc_seq = pc_q + PC_STEP;

  alu_seq_decode u_decode (
    .op_i  (op),
    .dec_o (dec)
  );

  always_comb begin
    rf_wa = ir_q[15:11];
    case (dec.dest_sel)
      DEST_RT:   rf_wa = ir_q[20:16];
      DEST_LINK: rf_wa = REG_LINK;
      default:   rf_wa = ir_q[15:11];
    endcase
    if (dec.dest_sel == DEST_LINK) begin
      rf_wd = pc_seq;
    end else if (dec.is_mem && !dec.is_store) begin
      rf_wd = ld_q;
    end else begin
      rf_wd = c_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    c_d       = c_q;
    jump_d    = jump_q;
    ld_d      = ld_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    commit    = 1'b0;
    pc_tgt    = pc_seq;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = HALT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        if (op == OP_HALT) begin
          state_d = HALT;
        end else if (dec.illegal) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        c_d    = alu_c;
        jump_d = alu_jump;
        wait_d = '0;
        if (dec.is_mem) begin
          state_d = MEM;
        end else if (dec.is_branch || op == OP_J) begin
          commit = 1'b1;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec.is_store;
        if (dmem_valid) begin
          wait_d = '0;
          if (dec.is_store) begin
            commit = 1'b1;
          end else begin
            ld_d    = dmem_rdata;
            state_d = WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = HALT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB: begin
        rf_we  = dec.writes_rf && (rf_wa != 5'd0);
        commit = 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Commit from EXEC uses the values being latched this edge, hence c_d/jump_d.
    if (dec.is_branch) begin
      pc_tgt = jump_d ? c_d : pc_seq;
    end else if (dec.is_jump) begin
      pc_tgt = c_d;
    end else if (dec.is_jr) begin
      pc_tgt = rf_rdata1;
    end

    if (commit) begin
      pc_d      = pc_tgt;
      retired_d = retired_q + 32'd1;
      state_d   = FETCH;
      wait_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      c_q       <= '0;
      jump_q    <= 1'b0;
      ld_q      <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      c_q       <= c_d;
      jump_q    <= jump_d;
      ld_q      <= ld_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = c_q;
  assign dmem_wdata = rf_rdata2;
  assign rf_ra1     = ir_q[25:21];
  assign rf_ra2     = ir_q[20:16];
  assign alu_ins    = ir_q;
  assign alu_pc     = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == HALT);
  assign fault      = fault_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed scoreboard bench for the multi-cycle sequencer
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wd;
  logic        rf_we;
  logic [31:0] alu_ins, alu_pc, alu_c;
  logic        alu_jump;
  logic [31:0] pc, retired;
  logic        halted, fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_wr[$];

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.PC_STEP(32'd1), .MEM_TIMEOUT(15), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_ins(alu_ins), .alu_pc(alu_pc), .alu_c(alu_c), .alu_jump(alu_jump),
    .pc(pc), .halted(halted), .fault(fault), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_rf_we", {27'd0, rf_wa}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
        chk("rf_wd", rf_wd, e.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic push(input logic [4:0] wa, input logic [31:0] wd);
    wr_t e;
    e.wa = wa;
    e.wd = wd;
    exp_wr.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ins);
    imem_rdata = ins;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic wait_fetch(input string tag, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (imem_req || halted) break;
    end
    chk({tag, "_back_in_fetch"}, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] c,
                     input logic j, input int lat);
    int n;
    alu_c    = c;
    alu_jump = j;
    fetch(ins);
    wait_fetch(tag, 10, n);
    if (lat > 0) chk({tag, "_latency"}, n + 1, lat);
    exp_ret++;
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_retired"}, retired, exp_ret);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    imem_valid = 1'b0; imem_rdata = '0;
    dmem_valid = 1'b0; dmem_rdata = '0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    alu_c = '0; alu_jump = 1'b0;
    exp_ret = 0;
    tick(); tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_flags", {28'd0, halted, fault, imem_req, dmem_req}, 32'd0);

    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, 32'd0);

    // add r3 = r1 + r2, ALU reports 7
    push(5'd3, 32'd7);
    exp_pc = 32'd1;
    alu_c = 32'd7;
    fetch(mk(6'd1, 5'd1, 5'd2, 16'h1800));
    tick();
    chk("add_alu_ins", alu_ins, mk(6'd1, 5'd1, 5'd2, 16'h1800));
    chk("add_alu_pc", alu_pc, 32'd0);
    chk("add_ra", {22'd0, rf_ra1, rf_ra2}, {22'd0, 5'd1, 5'd2});
    tick(); tick();
    chk("add_latency4_fetch", {31'd0, imem_req}, 32'd1);
    exp_ret++;
    chk("add_pc", pc, exp_pc);
    chk("add_retired", retired, exp_ret);

    exp_pc = 32'h20;
    run("beq_taken", mk(6'd16, 5'd1, 5'd2, 16'h0004), 32'h20, 1'b1, 3);
    exp_pc = 32'h21;
    run("beq_not_taken", mk(6'd16, 5'd1, 5'd2, 16'h0004), 32'h99, 1'b0, 3);

    // lw r5 with three wait cycles; alu_c changes afterwards to prove the address is latched
    alu_c = 32'h40;
    fetch(mk(6'd14, 5'd1, 5'd5, 16'h0010));
    tick(); tick();
    chk("lw_dmem_req", {31'd0, dmem_req}, 32'd1);
    chk("lw_dmem_addr", dmem_addr, 32'h40);
    chk("lw_dmem_we", {31'd0, dmem_we}, 32'd0);
    alu_c = 32'h1234;
    tick(); tick(); tick();
    chk("lw_held_req", {31'd0, dmem_req}, 32'd1);
    chk("lw_held_addr", dmem_addr, 32'h40);
    push(5'd5, 32'hDEAD_BEEF);
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_valid = 1'b1;
    tick();
    dmem_valid = 1'b0;
    dmem_rdata = '0;
    tick();
    exp_pc = 32'h22; exp_ret++;
    chk("lw_back_in_fetch", {31'd0, imem_req}, 32'd1);
    chk("lw_pc", pc, exp_pc);

    // sw with immediate completion: 4 cycles
    alu_c = 32'h44;
    rf_rdata2 = 32'hCAFE;
    fetch(mk(6'd15, 5'd1, 5'd6, 16'h0004));
    tick(); tick();
    chk("sw_dmem_we", {30'd0, dmem_req, dmem_we}, 32'd3);
    chk("sw_dmem_addr", dmem_addr, 32'h44);
    chk("sw_dmem_wdata", dmem_wdata, 32'hCAFE);
    dmem_valid = 1'b1;
    tick();
    dmem_valid = 1'b0;
    exp_pc = 32'h23; exp_ret++;
    chk("sw_back_in_fetch", {31'd0, imem_req}, 32'd1);
    chk("sw_pc", pc, exp_pc);
    chk("sw_retired", retired, exp_ret);

    exp_pc = 32'h24;
    run("addi_r0", mk(6'd10, 5'd1, 5'd0, 16'h0005), 32'd5, 1'b0, 4);
    push(5'd7, 32'hABC);
    exp_pc = 32'h25;
    run("ori_r7", mk(6'd12, 5'd1, 5'd7, 16'h0ABC), 32'hABC, 1'b0, 4);
    exp_pc = 32'h8;
    run("j", mk(6'd23, 5'd0, 5'd0, 16'h0008), 32'h8, 1'b0, 3);
    push(5'd31, 32'd9);
    exp_pc = 32'h100;
    run("jal", mk(6'd25, 5'd0, 5'd0, 16'h0100), 32'h100, 1'b0, 4);
    rf_rdata1 = 32'h55;
    exp_pc = 32'h55;
    run("jr", mk(6'd24, 5'd4, 5'd0, 16'h0000), 32'h77, 1'b0, 0);

    // reset while a load is outstanding; a late response must be ignored
    alu_c = 32'h60;
    fetch(mk(6'd14, 5'd1, 5'd9, 16'h0000));
    tick(); tick();
    chk("rstmem_req_before", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rstmem_req_dropped", {30'd0, dmem_req, imem_req}, 32'd0);
    chk("rstmem_pc", pc, 32'd0);
    chk("rstmem_retired", retired, 32'd0);
    rst = 1'b0;
    dmem_valid = 1'b1;
    dmem_rdata = 32'h1111_2222;
    tick(); tick();
    dmem_valid = 1'b0;
    chk("rstmem_stays_idle", {30'd0, imem_req, dmem_req}, 32'd0);

    // opcode 0 halts cleanly and ignores start
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(32'd0);
    tick();
    chk("halt_op0", {30'd0, halted, fault}, 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_ignores_start", {30'd0, halted, imem_req}, 32'd2);

    // opcode 63 is illegal
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_clears_halt", {30'd0, halted, fault}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    fetch(mk(6'd63, 5'd0, 5'd0, 16'h0000));
    tick();
    chk("illegal_op63", {30'd0, halted, fault}, 32'd3);

    // instruction memory never answers
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("timeout_not_yet", {30'd0, halted, imem_req}, 32'd1);
    tick();
    chk("timeout_fault", {30'd0, halted, fault}, 32'd3);

    chk("scoreboard_drained", exp_wr.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
